// File: rtl/ntsc_capture_write.sv
`default_nettype none
// ============================================================================
// Module   : ntsc_capture_write
// Purpose  : Packs horizontally adjacent decoded camera pixels (18-bit YCrCb)
//            into 36-bit frame-buffer words, even-x pixel in [17:0] and odd-x
//            pixel in [35:18]. Packed words are queued in a small FIFO and
//            written out through a request/done memory handshake that also
//            carries the (even x, y) address.
// Ports    : clk             - system clock, rising edge
//            rst_n           - asynchronous active-low reset
//            i_frame_start   - one-cycle pulse at start of a camera frame
//            i_pixel_valid   - pixel data/x/y valid this cycle
//            i_pixel_ycrcb   - {Y,Cr,Cb}, 6 bits each
//            i_pixel_x/y     - pixel column/row
//            i_done_ntsc     - memory side committed the current write
//            o_ntsc_flag     - write request
//            o_ntsc_pixel    - write data
//            o_ntsc_hcount   - write column (even x)
//            o_ntsc_vcount   - write row
//            o_fifo_count    - FIFO occupancy, 0..FIFO_DEPTH
//            o_overflow      - sticky: a packed word was dropped
//            o_drop_count    - dropped words, saturating at 255
// Revision : 1.0 - initial release
// ============================================================================
module ntsc_capture_write #(
  parameter int FIFO_DEPTH = 4,
  parameter int LOG_FIFO   = 2,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_frame_start,
  input  logic                i_pixel_valid,
  input  logic [17:0]         i_pixel_ycrcb,
  input  logic [9:0]          i_pixel_x,
  input  logic [9:0]          i_pixel_y,
  input  logic                i_done_ntsc,
  output logic                o_ntsc_flag,
  output logic [35:0]         o_ntsc_pixel,
  output logic [9:0]          o_ntsc_hcount,
  output logic [9:0]          o_ntsc_vcount,
  output logic [LOG_FIFO:0]   o_fifo_count,
  output logic                o_overflow,
  output logic [7:0]          o_drop_count
);

  localparam logic [10:0]       c_H_ACTIVE = 11'(H_ACTIVE);
  localparam logic [10:0]       c_V_ACTIVE = 11'(V_ACTIVE);
  localparam logic [LOG_FIFO:0] c_DEPTH    = (LOG_FIFO+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Pixel filter and pairing
  // --------------------------------------------------------------------------
  logic        w_accept;
  logic        w_pair;
  logic [9:0]  w_half_x_p1;

  logic        r_half_valid;
  logic [17:0] r_half_data;
  logic [9:0]  r_half_x;
  logic [9:0]  r_half_y;

  logic        r_word_valid;
  logic [35:0] r_word_data;
  logic [9:0]  r_word_x;
  logic [9:0]  r_word_y;

  assign w_accept    = i_pixel_valid &&
                       ({1'b0, i_pixel_x} < c_H_ACTIVE) &&
                       ({1'b0, i_pixel_y} < c_V_ACTIVE);
  assign w_half_x_p1 = r_half_x + 10'd1;
  // A frame_start in the same cycle as an odd pixel breaks the pair: the
  // stored even half belongs to the previous frame.
  assign w_pair      = w_accept && i_pixel_x[0] && r_half_valid && !i_frame_start &&
                       (r_half_y == i_pixel_y) && (w_half_x_p1 == i_pixel_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half_valid <= 1'b0;
      r_half_data  <= '0;
      r_half_x     <= '0;
      r_half_y     <= '0;
    end else if (w_accept && !i_pixel_x[0]) begin
      // An even pixel always wins, even over a coincident frame_start.
      r_half_valid <= 1'b1;
      r_half_data  <= i_pixel_ycrcb;
      r_half_x     <= i_pixel_x;
      r_half_y     <= i_pixel_y;
    end else if (i_frame_start || (w_accept && i_pixel_x[0])) begin
      r_half_valid <= 1'b0;
    end
  end

  // One-stage word register: the FIFO push happens on the edge after pairing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_valid <= 1'b0;
      r_word_data  <= '0;
      r_word_x     <= '0;
      r_word_y     <= '0;
    end else begin
      r_word_valid <= w_pair;
      if (w_pair) begin
        r_word_data <= {i_pixel_ycrcb, r_half_data};
        r_word_x    <= r_half_x;
        r_word_y    <= r_half_y;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Word FIFO: entry = {y, x, data}
  // --------------------------------------------------------------------------
  logic [55:0]         r_mem [FIFO_DEPTH];
  logic [LOG_FIFO-1:0] r_wr_ptr;
  logic [LOG_FIFO-1:0] r_rd_ptr;
  logic [LOG_FIFO:0]   r_count;
  logic                w_full;
  logic                w_push;
  logic                w_drop;
  logic                w_pop;
  logic                w_load;
  logic [55:0]         w_head;

  assign w_full = (r_count == c_DEPTH);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push = r_word_valid && (!w_full || w_pop);
  assign w_drop = r_word_valid && w_full && !w_pop;
  assign w_head = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_word_y, r_word_x, r_word_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (w_drop) begin
      o_overflow <= 1'b1;
      if (o_drop_count != 8'hFF) begin
        o_drop_count <= o_drop_count + 8'd1;
      end
    end
  end

  assign o_fifo_count = r_count;

  // --------------------------------------------------------------------------
  // Write-request FSM. The head word stays in the FIFO while it is being
  // written and is only popped on done, so occupancy includes it.
  // --------------------------------------------------------------------------
  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_load = 1'b1;
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (i_done_ntsc) begin
          w_pop  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ntsc_flag   <= 1'b0;
      o_ntsc_pixel  <= '0;
      o_ntsc_hcount <= '0;
      o_ntsc_vcount <= '0;
    end else if (w_load) begin
      o_ntsc_flag   <= 1'b1;
      o_ntsc_pixel  <= w_head[35:0];
      o_ntsc_hcount <= w_head[45:36];
      o_ntsc_vcount <= w_head[55:46];
    end else if (w_pop) begin
      o_ntsc_flag <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ntsc_capture_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntsc_capture_write
// Purpose  : Directed self-checking bench for ntsc_capture_write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntsc_capture_write;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        pixel_valid;
  logic [17:0] pixel_ycrcb;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        done_ntsc;
  logic        ntsc_flag;
  logic [35:0] ntsc_pixel;
  logic [9:0]  ntsc_hcount;
  logic [9:0]  ntsc_vcount;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;

  int checks;
  int errors;

  ntsc_capture_write #(
    .FIFO_DEPTH(4), .LOG_FIFO(2), .H_ACTIVE(640), .V_ACTIVE(480)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frame_start (frame_start),
    .i_pixel_valid (pixel_valid),
    .i_pixel_ycrcb (pixel_ycrcb),
    .i_pixel_x     (pixel_x),
    .i_pixel_y     (pixel_y),
    .i_done_ntsc   (done_ntsc),
    .o_ntsc_flag   (ntsc_flag),
    .o_ntsc_pixel  (ntsc_pixel),
    .o_ntsc_hcount (ntsc_hcount),
    .o_ntsc_vcount (ntsc_vcount),
    .o_fifo_count  (fifo_count),
    .o_overflow    (overflow),
    .o_drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [17:0] d);
    pixel_valid = 1'b1;
    pixel_x     = x;
    pixel_y     = y;
    pixel_ycrcb = d;
    tick();
    pixel_valid = 1'b0;
  endtask

  // Pulses done when a request is pending; bounded wait for the request.
  task automatic drain_one(input string name, input logic [35:0] exp_pix,
                           input logic [9:0] exp_h, input logic [9:0] exp_v);
    int n;
    n = 0;
    while (ntsc_flag !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (ntsc_flag !== 1'b1) begin
      errors++;
      $display("FAIL %s flag timeout: got %b want 1", name, ntsc_flag);
    end
    checks++;
    if (ntsc_pixel !== exp_pix || ntsc_hcount !== exp_h || ntsc_vcount !== exp_v) begin
      errors++;
      $display("FAIL %s word: got %h/%0d/%0d want %h/%0d/%0d", name,
               ntsc_pixel, ntsc_hcount, ntsc_vcount, exp_pix, exp_h, exp_v);
    end
    done_ntsc = 1'b1;
    tick();
    done_ntsc = 1'b0;
    checks++;
    if (ntsc_flag !== 1'b0) begin
      errors++;
      $display("FAIL %s flag after done: got %b want 0", name, ntsc_flag);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (ntsc_flag !== 1'b0 || ntsc_pixel !== 36'd0 || ntsc_hcount !== 10'd0 ||
        ntsc_vcount !== 10'd0 || fifo_count !== 3'd0 || overflow !== 1'b0 ||
        drop_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got flag=%b pix=%h h=%0d v=%0d cnt=%0d ovf=%b drop=%0d want all 0",
               ntsc_flag, ntsc_pixel, ntsc_hcount, ntsc_vcount, fifo_count, overflow, drop_count);
    end
  endtask

  task automatic test_basic_pair();
    pix(10'd4, 10'd10, 18'h15555);
    pix(10'd5, 10'd10, 18'h2AAAA);
    tick();
    checks++;
    if (fifo_count !== 3'd1 || ntsc_flag !== 1'b0) begin
      errors++;
      $display("FAIL basic_push: got cnt=%0d flag=%b want 1/0", fifo_count, ntsc_flag);
    end
    tick();
    checks++;
    if (ntsc_flag !== 1'b1 || ntsc_pixel !== 36'hAAAA95555 || ntsc_hcount !== 10'd4 ||
        ntsc_vcount !== 10'd10) begin
      errors++;
      $display("FAIL basic_req: got flag=%b pix=%h h=%0d v=%0d want 1/aaaa95555/4/10",
               ntsc_flag, ntsc_pixel, ntsc_hcount, ntsc_vcount);
    end
    tick();
    tick();
    checks++;
    if (ntsc_flag !== 1'b1 || fifo_count !== 3'd1 || ntsc_pixel !== 36'hAAAA95555) begin
      errors++;
      $display("FAIL basic_hold: got flag=%b cnt=%0d pix=%h want 1/1/aaaa95555",
               ntsc_flag, fifo_count, ntsc_pixel);
    end
    done_ntsc = 1'b1;
    tick();
    done_ntsc = 1'b0;
    checks++;
    if (ntsc_flag !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL basic_done: got flag=%b cnt=%0d want 0/0", ntsc_flag, fifo_count);
    end
  endtask

  task automatic test_mismatch();
    pix(10'd4, 10'd10, 18'h00001);
    pix(10'd7, 10'd10, 18'h00002);
    tick(); tick(); tick();
    checks++;
    if (fifo_count !== 3'd0 || ntsc_flag !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_x: got cnt=%0d flag=%b want 0/0", fifo_count, ntsc_flag);
    end
    pix(10'd4, 10'd10, 18'h00003);
    pix(10'd5, 10'd11, 18'h00004);
    tick(); tick(); tick();
    checks++;
    if (fifo_count !== 3'd0 || ntsc_flag !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL mismatch_y: got cnt=%0d flag=%b drop=%0d want 0/0/0",
               fifo_count, ntsc_flag, drop_count);
    end
  endtask

  task automatic test_boundaries();
    // An accepted x=640 pixel would overwrite the stored even half and break the pair.
    pix(10'd638, 10'd10, 18'h00011);
    pix(10'd640, 10'd10, 18'h3FFFF);
    pix(10'd639, 10'd10, 18'h00022);
    drain_one("bound_x", {18'h00022, 18'h00011}, 10'd638, 10'd10);
    pix(10'd2, 10'd20, 18'h00033);
    pix(10'd2, 10'd480, 18'h3FFFF);
    pix(10'd3, 10'd20, 18'h00044);
    drain_one("bound_y", {18'h00044, 18'h00033}, 10'd2, 10'd20);
    // frame_start between halves kills the pair.
    pix(10'd4, 10'd10, 18'h00055);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pix(10'd5, 10'd10, 18'h00066);
    tick(); tick(); tick();
    checks++;
    if (fifo_count !== 3'd0 || ntsc_flag !== 1'b0) begin
      errors++;
      $display("FAIL frame_start_break: got cnt=%0d flag=%b want 0/0", fifo_count, ntsc_flag);
    end
    // frame_start coincident with an even pixel keeps the new pixel.
    frame_start = 1'b1;
    pix(10'd6, 10'd12, 18'h00077);
    frame_start = 1'b0;
    pix(10'd7, 10'd12, 18'h00088);
    drain_one("frame_start_even", {18'h00088, 18'h00077}, 10'd6, 10'd12);
    // done in IDLE has no effect.
    tick(); tick();
    done_ntsc = 1'b1;
    tick();
    done_ntsc = 1'b0;
    tick();
    checks++;
    if (fifo_count !== 3'd0 || ntsc_flag !== 1'b0 || ntsc_hcount !== 10'd6 ||
        ntsc_pixel !== {18'h00088, 18'h00077}) begin
      errors++;
      $display("FAIL done_idle: got cnt=%0d flag=%b h=%0d pix=%h want 0/0/6/%h",
               fifo_count, ntsc_flag, ntsc_hcount, ntsc_pixel, {18'h00088, 18'h00077});
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      pix(10'(2*i), 10'd1, 18'(i + 16'h100));
      pix(10'(2*i+1), 10'd1, 18'(i + 16'h200));
    end
    tick(); tick(); tick();
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1 || drop_count !== 8'd2) begin
      errors++;
      $display("FAIL overflow: got cnt=%0d ovf=%b drop=%0d want 4/1/2",
               fifo_count, overflow, drop_count);
    end
    for (int k = 0; k < 4; k++) begin
      drain_one("overflow_drain", {18'(k + 16'h200), 18'(k + 16'h100)}, 10'(2*k), 10'd1);
    end
    tick(); tick();
    checks++;
    if (fifo_count !== 3'd0 || ntsc_flag !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_empty: got cnt=%0d flag=%b ovf=%b want 0/0/1",
               fifo_count, ntsc_flag, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      pix(10'(20 + 2*i), 10'd2, 18'(i + 16'h300));
      pix(10'(21 + 2*i), 10'd2, 18'(i + 16'h400));
    end
    tick(); tick();
    checks++;
    if (fifo_count !== 3'd4 || ntsc_flag !== 1'b1) begin
      errors++;
      $display("FAIL full_setup: got cnt=%0d flag=%b want 4/1", fifo_count, ntsc_flag);
    end
    pix(10'd40, 10'd2, 18'h00500);
    pix(10'd41, 10'd2, 18'h00600);
    // The word pushes on the next edge, together with this done.
    done_ntsc = 1'b1;
    tick();
    done_ntsc = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || drop_count !== 8'd2 || ntsc_flag !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop: got cnt=%0d drop=%0d flag=%b want 4/2/0",
               fifo_count, drop_count, ntsc_flag);
    end
    for (int k = 1; k < 4; k++) begin
      drain_one("full_drain", {18'(k + 16'h400), 18'(k + 16'h300)}, 10'(20 + 2*k), 10'd2);
    end
    drain_one("full_drain_new", {18'h00600, 18'h00500}, 10'd40, 10'd2);
  endtask

  task automatic test_async_reset();
    pix(10'd8, 10'd30, 18'h0ABCD);
    pix(10'd9, 10'd30, 18'h01234);
    tick(); tick();
    checks++;
    if (ntsc_flag !== 1'b1) begin
      errors++;
      $display("FAIL async_setup: got flag=%b want 1", ntsc_flag);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ntsc_flag !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL async_reset_now: got flag=%b cnt=%0d want 0/0", ntsc_flag, fifo_count);
    end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (ntsc_flag !== 1'b0 || ntsc_pixel !== 36'd0 || ntsc_hcount !== 10'd0 ||
        ntsc_vcount !== 10'd0 || fifo_count !== 3'd0 || overflow !== 1'b0 ||
        drop_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset_after: got flag=%b pix=%h h=%0d v=%0d cnt=%0d ovf=%b drop=%0d want all 0",
               ntsc_flag, ntsc_pixel, ntsc_hcount, ntsc_vcount, fifo_count, overflow, drop_count);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_ycrcb = '0;
    pixel_x     = '0;
    pixel_y     = '0;
    done_ntsc   = 1'b0;
    #1;
    test_reset();
    test_basic_pair();
    test_mismatch();
    test_boundaries();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
